addsub_seq_ctrl: RTL

//  Multi-cycle n-bit add/subtract engine. Accepts one operand pair over a valid/ready

---
 rtl/addsub_seq_ctrl_pkg.sv | 11 +
 rtl/addsub_seq_ctrl_chunk.sv | 26 ++
 rtl/addsub_seq_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/addsub_seq_ctrl_pkg.sv
// Shared constants for the chunked add/subtract engine: FSM encodings and default widths.
package addsub_seq_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int unsigned DEFAULT_N = 32;
    localparam int unsigned DEFAULT_K = 8;

endpackage

// File: rtl/addsub_seq_ctrl_chunk.sv
// K-bit combinational ripple slice built from full-adder cells.
// Exposes the carry into the top bit so the caller can derive signed overflow.
module addsub_seq_ctrl_chunk #(
    parameter int unsigned K = 8
) (
    input  logic [K-1:0] a,
    input  logic [K-1:0] b,
    input  logic         cin,
    output logic [K-1:0] s,
    output logic         cout,
    output logic         cmsb
);

    logic [K:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < K; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[K];
    assign cmsb = c[K-1];

endmodule

// File: rtl/addsub_seq_ctrl.sv
// Multi-cycle N-bit add/subtract engine resolving K bits per cycle through one ripple slice,
// with valid/ready handshakes on both sides and registered result/flags.
module addsub_seq_ctrl
    import addsub_seq_ctrl_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N,
    parameter int unsigned K = DEFAULT_K
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         carry,
    output logic         overflow,
    output logic         zero
);

    localparam int unsigned NC = N / K;
    localparam int unsigned IW = (NC > 1) ? $clog2(NC) : 1;

    if ((N % K != 0) || (N < 4) || (N > 256) || (N % 4 != 0)) begin : g_param_err
        $error("addsub_seq_ctrl: N must be 4..256, a multiple of 4, and a multiple of K");
    end

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  res_q, res_d;
    logic [N-1:0]  sum_q, sum_d;
    logic          cy_q, cy_d;
    logic          carry_q, carry_d;
    logic          ovf_q, ovf_d;
    logic          zero_q, zero_d;

    logic [K-1:0]  ch_s;
    logic          ch_cout;
    logic          ch_cmsb;
    logic [N-1:0]  res_next;

    // Operands are consumed from the low end; each new result chunk enters at the top.
    addsub_seq_ctrl_chunk #(
        .K (K)
    ) u_chunk (
        .a    (a_q[K-1:0]),
        .b    (b_q[K-1:0]),
        .cin  (cy_q),
        .s    (ch_s),
        .cout (ch_cout),
        .cmsb (ch_cmsb)
    );

    assign res_next = (res_q >> K) | (N'(ch_s) << (N - K));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cy_d    = cy_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b ^ {N{sub}};
                    cy_d    = sub;
                    idx_d   = '0;
                    res_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d   = a_q >> K;
                b_d   = b_q >> K;
                res_d = res_next;
                cy_d  = ch_cout;
                idx_d = idx_q + IW'(1);
                if (idx_q == IW'(NC - 1)) begin
                    sum_d   = res_next;
                    carry_d = ch_cout;
                    ovf_d   = ch_cmsb ^ ch_cout;
                    zero_d  = (res_next == '0);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cy_q    <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cy_q    <= cy_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule
